// File: rtl/axi_txn_scheduler.sv
// Weighted round-robin scheduler for one shared AXI address channel.
// Each requester gets up to weight+1 consecutive grants before the pointer moves on.
// Grants are suppressed for requesters whose outstanding count has reached the cap.
// Outstanding counts are released by completion pulses (done_valid/done_idx).
module axi_txn_scheduler #(
   parameter int REQ_NUM         = 4,
   parameter int IDX_WIDTH       = $clog2(REQ_NUM),
   parameter int MAX_OUTSTANDING = 8,
   parameter int CNT_WIDTH       = $clog2(MAX_OUTSTANDING + 1),
   parameter int WEIGHT_WIDTH    = 4
) (
   input  logic                            clk,
   input  logic                            rstn,
   input  logic [REQ_NUM-1:0]              req_valid,
   input  logic [REQ_NUM*WEIGHT_WIDTH-1:0] weight,
   output logic                            grant_valid,
   output logic [REQ_NUM-1:0]              grant_onehot,
   output logic [IDX_WIDTH-1:0]            grant_idx,
   input  logic                            grant_ready,
   input  logic                            done_valid,
   input  logic [IDX_WIDTH-1:0]            done_idx,
   output logic [REQ_NUM*CNT_WIDTH-1:0]    outstanding,
   output logic [REQ_NUM-1:0]              at_limit,
   output logic                            err_underflow
);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   localparam logic [IDX_WIDTH:0]   REQ_NUM_W = (IDX_WIDTH + 1)'(REQ_NUM);
   localparam logic [IDX_WIDTH-1:0] LAST_IDX  = IDX_WIDTH'(REQ_NUM - 1);
   localparam logic [CNT_WIDTH-1:0] MAX_CNT   = CNT_WIDTH'(MAX_OUTSTANDING);

   state_t                  state_reg, state_next;
   logic [IDX_WIDTH-1:0]    grant_idx_reg, grant_idx_next;
   logic [IDX_WIDTH-1:0]    rr_ptr_reg, rr_ptr_next;
   logic [WEIGHT_WIDTH-1:0] burst_reg, burst_next;
   logic                    err_reg;

   logic [CNT_WIDTH-1:0]    cnt_arr    [REQ_NUM];
   logic [WEIGHT_WIDTH-1:0] weight_arr [REQ_NUM];
   logic [IDX_WIDTH-1:0]    cand_idx   [REQ_NUM];
   logic [REQ_NUM-1:0]      eligible;
   logic [REQ_NUM-1:0]      cnt_zero;
   logic [IDX_WIDTH-1:0]    sel_idx;
   logic                    sel_found;
   logic                    handshake;
   logic                    done_in_range;
   logic                    done_ok;

   // A completion is only honoured for an existing requester with something in flight.
   assign done_in_range = ({1'b0, done_idx} < REQ_NUM_W);
   assign done_ok       = done_valid && done_in_range && !cnt_zero[done_idx];

   assign eligible    = req_valid & ~at_limit;
   assign grant_valid = (state_reg == GRANT);
   assign grant_idx   = grant_idx_reg;
   assign err_underflow = err_reg;

   generate
      for (genvar gi = 0; gi < REQ_NUM; gi++) begin : g_req
         logic [CNT_WIDTH-1:0] cnt_reg;
         logic [IDX_WIDTH:0]   rot_sum;
         logic                 inc;
         logic                 dec;

         assign weight_arr[gi] = weight[gi*WEIGHT_WIDTH +: WEIGHT_WIDTH];
         assign cnt_arr[gi]    = cnt_reg;
         assign outstanding[gi*CNT_WIDTH +: CNT_WIDTH] = cnt_reg;
         assign at_limit[gi]   = (cnt_reg == MAX_CNT);
         assign cnt_zero[gi]   = (cnt_reg == '0);
         assign grant_onehot[gi] = grant_valid && (grant_idx_reg == IDX_WIDTH'(gi));

         // Candidate gi is the requester gi positions after the rr pointer, wrapped.
         assign rot_sum      = {1'b0, rr_ptr_reg} + (IDX_WIDTH + 1)'(gi);
         assign cand_idx[gi] = (rot_sum >= REQ_NUM_W) ? IDX_WIDTH'(rot_sum - REQ_NUM_W)
                                                      : rot_sum[IDX_WIDTH-1:0];

         assign inc = handshake && (grant_idx_reg == IDX_WIDTH'(gi));
         assign dec = done_ok && (done_idx == IDX_WIDTH'(gi));

         // In-flight counter: a grant and a completion on the same requester cancel out.
         always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
               cnt_reg <= '0;
            end else if (inc && !dec) begin
               cnt_reg <= cnt_reg + 1'b1;
            end else if (dec && !inc) begin
               cnt_reg <= cnt_reg - 1'b1;
            end
         end
      end
   endgenerate

   // Pick the first eligible requester at or after the rr pointer (lowest offset wins).
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = rr_ptr_reg;
      for (int k = REQ_NUM - 1; k >= 0; k--) begin
         if (eligible[cand_idx[k]]) begin
            sel_found = 1'b1;
            sel_idx   = cand_idx[k];
         end
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next state, selection capture and weighted pointer advance on each handshake.
   always_comb begin
      state_next     = state_reg;
      grant_idx_next = grant_idx_reg;
      rr_ptr_next    = rr_ptr_reg;
      burst_next     = burst_reg;
      handshake      = 1'b0;
      case (state_reg)
         IDLE: begin
            if (sel_found) begin
               state_next     = GRANT;
               grant_idx_next = sel_idx;
               // Skipping past the pointer starts a fresh burst for the new owner.
               if (sel_idx != rr_ptr_reg) begin
                  burst_next = '0;
               end
            end
         end
         GRANT: begin
            if (grant_ready) begin
               handshake  = 1'b1;
               state_next = IDLE;
               if (burst_reg < weight_arr[grant_idx_reg]) begin
                  burst_next  = burst_reg + 1'b1;
                  rr_ptr_next = grant_idx_reg;
               end else begin
                  burst_next  = '0;
                  rr_ptr_next = (grant_idx_reg == LAST_IDX) ? '0 : grant_idx_reg + 1'b1;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Selection, pointer and burst registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         grant_idx_reg <= '0;
         rr_ptr_reg    <= '0;
         burst_reg     <= '0;
      end else begin
         grant_idx_reg <= grant_idx_next;
         rr_ptr_reg    <= rr_ptr_next;
         burst_reg     <= burst_next;
      end
   end

   // Sticky underflow flag: completion for an unknown requester or an empty counter.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         err_reg <= 1'b0;
      end else if (done_valid && (!done_in_range || cnt_zero[done_idx])) begin
         err_reg <= 1'b1;
      end
   end

endmodule

// File: tb/tb_axi_txn_scheduler.sv
// Bench for axi_txn_scheduler: directed scenarios plus a randomized run, all
// checked against a transaction-level reference model of the scheduling rules.
module tb_axi_txn_scheduler;

   localparam int N   = 4;
   localparam int MAX = 8;

   logic        clk = 1'b0;
   logic        rstn;
   logic [3:0]  req_valid;
   logic [15:0] weight;
   logic        grant_valid;
   logic [3:0]  grant_onehot;
   logic [1:0]  grant_idx;
   logic        grant_ready;
   logic        done_valid;
   logic [1:0]  done_idx;
   logic [15:0] outstanding;
   logic [3:0]  at_limit;
   logic        err_underflow;

   int checks = 0;
   int errors = 0;

   // reference model state
   int m_cnt [N];
   bit m_busy;
   int m_idx;
   int m_rr;
   int m_burst;
   bit m_err;

   axi_txn_scheduler dut (
      .clk          (clk),
      .rstn         (rstn),
      .req_valid    (req_valid),
      .weight       (weight),
      .grant_valid  (grant_valid),
      .grant_onehot (grant_onehot),
      .grant_idx    (grant_idx),
      .grant_ready  (grant_ready),
      .done_valid   (done_valid),
      .done_idx     (done_idx),
      .outstanding  (outstanding),
      .at_limit     (at_limit),
      .err_underflow(err_underflow)
   );

   always #5 clk = ~clk;

   function automatic void model_reset();
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
      m_busy  = 0;
      m_idx   = 0;
      m_rr    = 0;
      m_burst = 0;
      m_err   = 0;
   endfunction

   // Apply one clock's worth of scheduling rules to the model, using the driven inputs.
   function automatic void model_step();
      int inc_i;
      int dec_i;
      int w;
      bit [3:0] elig;
      inc_i = -1;
      dec_i = -1;
      for (int i = 0; i < N; i++) elig[i] = req_valid[i] && (m_cnt[i] < MAX);
      if (!m_busy) begin
         for (int k = 0; k < N; k++) begin
            int c;
            c = (m_rr + k) % N;
            if (elig[c]) begin
               if (c != m_rr) m_burst = 0;
               m_idx  = c;
               m_busy = 1;
               break;
            end
         end
      end else if (grant_ready) begin
         inc_i = m_idx;
         w = int'(weight[m_idx*4 +: 4]);
         if (m_burst < w) begin
            m_burst = m_burst + 1;
            m_rr    = m_idx;
         end else begin
            m_burst = 0;
            m_rr    = (m_idx + 1) % N;
         end
         m_busy = 0;
      end
      if (done_valid) begin
         if (int'(done_idx) >= N || m_cnt[done_idx] == 0) m_err = 1;
         else dec_i = int'(done_idx);
      end
      if (inc_i >= 0) m_cnt[inc_i] = m_cnt[inc_i] + 1;
      if (dec_i >= 0) m_cnt[dec_i] = m_cnt[dec_i] - 1;
   endfunction

   function automatic logic [27:0] exp_vec();
      logic [3:0]  oh;
      logic [3:0]  lim;
      logic [15:0] outs;
      oh = m_busy ? (4'b0001 << m_idx) : 4'b0000;
      for (int i = 0; i < N; i++) begin
         outs[i*4 +: 4] = 4'(m_cnt[i]);
         lim[i] = (m_cnt[i] == MAX);
      end
      return {m_busy, oh, 2'(m_idx), outs, lim, m_err};
   endfunction

   function automatic logic [27:0] obs_vec();
      return {grant_valid, grant_onehot, grant_idx, outstanding, at_limit, err_underflow};
   endfunction

   task automatic step();
      model_step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rstn        = 1'b0;
      req_valid   = '0;
      grant_ready = 1'b0;
      done_valid  = 1'b0;
      done_idx    = '0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rstn = 1'b1;
   endtask

   task automatic test_reset();
      weight = '0;
      do_reset();
      checks++;
      if (obs_vec() !== 28'h0) begin
         errors++;
         $display("FAIL reset_state: got %h expected %h", obs_vec(), 28'h0);
      end
      step();
      checks++;
      if (obs_vec() !== exp_vec()) begin
         errors++;
         $display("FAIL reset_idle: got %h expected %h", obs_vec(), exp_vec());
      end
   endtask

   task automatic test_single();
      do_reset();
      weight = '0;
      req_valid = 4'b0001;
      grant_ready = 1'b1;
      step();
      checks++;
      if (grant_valid !== 1'b1 || grant_idx !== 2'd0) begin
         errors++;
         $display("FAIL single_latency: got valid=%b idx=%0d expected valid=1 idx=0", grant_valid, grant_idx);
      end
      for (int s = 0; s < 20; s++) begin
         if (grant_valid && grant_ready) $display("single: handshake idx=%0d outstanding0=%0d", grant_idx, outstanding[3:0]);
         step();
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL single_model: got %h expected %h", obs_vec(), exp_vec());
         end
      end
      checks++;
      if (outstanding[3:0] !== 4'd8 || at_limit[0] !== 1'b1 || grant_valid !== 1'b0) begin
         errors++;
         $display("FAIL single_limit: got cnt=%0d lim=%b valid=%b expected cnt=8 lim=1 valid=0", outstanding[3:0], at_limit[0], grant_valid);
      end
      req_valid = '0;
      done_valid = 1'b1;
      done_idx = 2'd0;
      for (int s = 0; s < 8; s++) step();
      done_valid = 1'b0;
      checks++;
      if (outstanding !== 16'h0 || err_underflow !== 1'b0) begin
         errors++;
         $display("FAIL single_drain: got out=%h err=%b expected out=0000 err=0", outstanding, err_underflow);
      end
   endtask

   task automatic test_round_robin();
      int order[$];
      int exp_o[5] = '{0, 1, 2, 3, 0};
      do_reset();
      weight = '0;
      req_valid = 4'b1111;
      grant_ready = 1'b1;
      for (int s = 0; s < 10; s++) begin
         step();
         if (grant_valid) begin
            order.push_back(int'(grant_idx));
            $display("rr: grant idx=%0d", grant_idx);
         end
         if (s == 7) begin
            checks++;
            if (outstanding !== 16'h1111) begin
               errors++;
               $display("FAIL rr_counts: got %h expected 1111", outstanding);
            end
         end
      end
      checks++;
      if (order.size() != 5) begin
         errors++;
         $display("FAIL rr_count_grants: got %0d expected 5", order.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            checks++;
            if (order[i] != exp_o[i]) begin
               errors++;
               $display("FAIL rr_order[%0d]: got %0d expected %0d", i, order[i], exp_o[i]);
            end
         end
      end
   endtask

   task automatic test_weighted();
      int order[$];
      int exp_o[8] = '{0, 0, 0, 1, 0, 0, 0, 1};
      do_reset();
      weight = 16'h0002;
      req_valid = 4'b0011;
      grant_ready = 1'b1;
      for (int s = 0; s < 16; s++) begin
         step();
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL weighted_model: got %h expected %h", obs_vec(), exp_vec());
         end
         if (grant_valid) begin
            order.push_back(int'(grant_idx));
            $display("weighted: grant idx=%0d", grant_idx);
         end
      end
      checks++;
      if (order.size() != 8) begin
         errors++;
         $display("FAIL weighted_count: got %0d expected 8", order.size());
      end else begin
         for (int i = 0; i < 8; i++) begin
            checks++;
            if (order[i] != exp_o[i]) begin
               errors++;
               $display("FAIL weighted_order[%0d]: got %0d expected %0d", i, order[i], exp_o[i]);
            end
         end
      end
   endtask

   task automatic test_limit_release();
      int ones;
      int zeros;
      bit found;
      do_reset();
      weight = '0;
      req_valid = 4'b0010;
      grant_ready = 1'b1;
      for (int s = 0; s < 16; s++) step();
      checks++;
      if (at_limit !== 4'b0010 || outstanding[7:4] !== 4'd8) begin
         errors++;
         $display("FAIL limit_fill: got lim=%b cnt1=%0d expected lim=0010 cnt1=8", at_limit, outstanding[7:4]);
      end
      req_valid = 4'b0011;
      ones = 0;
      zeros = 0;
      for (int s = 0; s < 10; s++) begin
         step();
         if (grant_valid && grant_idx == 2'd1) ones++;
         if (grant_valid && grant_idx == 2'd0) zeros++;
      end
      checks++;
      if (ones != 0 || zeros == 0) begin
         errors++;
         $display("FAIL limit_skip: got grants1=%0d grants0=%0d expected grants1=0 grants0>0", ones, zeros);
      end
      done_valid = 1'b1;
      done_idx = 2'd1;
      step();
      done_valid = 1'b0;
      checks++;
      if (outstanding[7:4] !== 4'd7) begin
         errors++;
         $display("FAIL limit_release: got cnt1=%0d expected 7", outstanding[7:4]);
      end
      found = 0;
      for (int s = 0; s < 6; s++) begin
         step();
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL limit_model: got %h expected %h", obs_vec(), exp_vec());
         end
         if (grant_valid && grant_idx == 2'd1) begin
            found = 1;
            $display("limit: requester 1 granted again");
         end
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL limit_regrant: got no grant to 1 within 6 cycles, required one");
      end
   endtask

   task automatic test_simultaneous();
      do_reset();
      weight = '0;
      req_valid = 4'b0100;
      grant_ready = 1'b1;
      for (int s = 0; s < 7; s++) step();
      checks++;
      if (outstanding[11:8] !== 4'd3 || grant_valid !== 1'b1 || grant_idx !== 2'd2) begin
         errors++;
         $display("FAIL simul_setup: got cnt2=%0d valid=%b idx=%0d expected 3 1 2", outstanding[11:8], grant_valid, grant_idx);
      end
      req_valid = '0;
      done_valid = 1'b1;
      done_idx = 2'd2;
      step();
      checks++;
      if (outstanding[11:8] !== 4'd3 || err_underflow !== 1'b0) begin
         errors++;
         $display("FAIL simul_same_idx: got cnt2=%0d err=%b expected cnt2=3 err=0", outstanding[11:8], err_underflow);
      end
      done_idx = 2'd3;
      step();
      done_valid = 1'b0;
      checks++;
      if (err_underflow !== 1'b1 || outstanding[15:12] !== 4'd0) begin
         errors++;
         $display("FAIL simul_underflow: got err=%b cnt3=%0d expected err=1 cnt3=0", err_underflow, outstanding[15:12]);
      end
      step();
      checks++;
      if (obs_vec() !== exp_vec()) begin
         errors++;
         $display("FAIL simul_model: got %h expected %h", obs_vec(), exp_vec());
      end
   endtask

   task automatic test_backpressure_reset();
      logic [1:0] held_idx;
      logic [3:0] held_oh;
      do_reset();
      weight = '0;
      req_valid = 4'b1000;
      grant_ready = 1'b1;
      step();
      step();
      grant_ready = 1'b0;
      step();
      held_idx = grant_idx;
      held_oh = grant_onehot;
      checks++;
      if (held_idx !== 2'd3 || held_oh !== 4'b1000 || outstanding[15:12] !== 4'd1) begin
         errors++;
         $display("FAIL bp_setup: got idx=%0d oh=%b cnt3=%0d expected 3 1000 1", held_idx, held_oh, outstanding[15:12]);
      end
      for (int s = 0; s < 10; s++) begin
         step();
         checks++;
         if (grant_valid !== 1'b1 || grant_idx !== held_idx || grant_onehot !== held_oh) begin
            errors++;
            $display("FAIL bp_stable: got valid=%b idx=%0d oh=%b expected 1 %0d %b", grant_valid, grant_idx, grant_onehot, held_idx, held_oh);
         end
      end
      #2 rstn = 1'b0;
      #1;
      checks++;
      if (obs_vec() !== 28'h0) begin
         errors++;
         $display("FAIL async_reset: got %h expected %h", obs_vec(), 28'h0);
      end
      $display("bp: async reset applied mid-grant");
      model_reset();
      req_valid = '0;
      @(negedge clk);
      rstn = 1'b1;
   endtask

   task automatic test_random();
      int fails_shown = 0;
      int di;
      do_reset();
      weight = 16'($urandom);
      for (int s = 0; s < 3000; s++) begin
         req_valid = 4'($urandom);
         grant_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 15) == 0) weight = 16'($urandom);
         done_valid = 1'b0;
         if ($urandom_range(0, 2) == 0) begin
            di = int'($urandom_range(0, N - 1));
            if (m_cnt[di] > 0 || ($urandom_range(0, 49) == 0 && !(m_busy && grant_ready && m_idx == di))) begin
               done_valid = 1'b1;
               done_idx = 2'(di);
            end
         end
         step();
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++;
            if (fails_shown < 10) begin
               fails_shown++;
               $display("FAIL random_cycle%0d: got %h expected %h", s, obs_vec(), exp_vec());
            end
         end
      end
      done_valid = 1'b0;
   endtask

   initial begin
      rstn = 1'b0;
      req_valid = '0;
      weight = '0;
      grant_ready = 1'b0;
      done_valid = 1'b0;
      done_idx = '0;
      model_reset();
      test_reset();
      test_single();
      test_round_robin();
      test_weighted();
      test_limit_release();
      test_simultaneous();
      test_backpressure_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/axi_txn_scheduler.md
Name: axi_txn_scheduler

Overview:
- Weighted round-robin scheduler that shares one downstream AXI address channel (AW or AR) among REQ_NUM requesters.
- Caps the outstanding transactions per requester, so one master cannot flood the shared slave.
- Sits in front of the multi-master AXI mux. One instance drives AW selection, a second drives AR selection.
- Outstanding counts are released by response completion: the B handshake, or the R handshake carrying r_last.

Parameters:
- REQ_NUM, 4, number of requesters (at least 2).
- IDX_WIDTH, $clog2(REQ_NUM), width of a requester index.
- MAX_OUTSTANDING, 8, maximum in-flight transactions per requester (at least 1).
- CNT_WIDTH, $clog2(MAX_OUTSTANDING+1), width of the outstanding counter.
- WEIGHT_WIDTH, 4, width of the per-requester weight field.

Ports:
- clk, input, 1, clock.
- rstn, input, 1, asynchronous active-low reset.
- req_valid, input, REQ_NUM, per-requester address valid.
- weight, input, REQ_NUM*WEIGHT_WIDTH, quasi-static config; requester i is granted up to weight[i]+1 consecutive times.
- grant_valid, output, 1, a grant is presented downstream.
- grant_onehot, output, REQ_NUM, one-hot selected requester; zero when grant_valid=0.
- grant_idx, output, IDX_WIDTH, binary selected requester; holds its last value when idle.
- grant_ready, input, 1, downstream address handshake completes this cycle.
- done_valid, input, 1, one transaction completed.
- done_idx, input, IDX_WIDTH, requester owning the completed transaction.
- outstanding, output, REQ_NUM*CNT_WIDTH, per-requester in-flight count.
- at_limit, output, REQ_NUM, outstanding[i] == MAX_OUTSTANDING.
- err_underflow, output, 1, sticky error flag; cleared only by reset.

Behaviour:
- Reset values: grant_valid=0, grant_onehot=0, grant_idx=0, all outstanding=0, at_limit=0, err_underflow=0, state=IDLE, rr pointer=0, burst counter=0.
- Eligibility: eligible = req_valid & ~at_limit.
- IDLE state:
  - If eligible is nonzero, pick the first eligible index at or after the rr pointer, wrapping modulo REQ_NUM.
  - Register that index into grant_idx/grant_onehot and go to GRANT. Grant latency is 1 cycle from req_valid.
  - If eligible is zero, stay in IDLE.
- GRANT state:
  - grant_valid=1. The selection is frozen until grant_ready, independent of req_valid.
  - Requesters obey the AXI rule that valid is not withdrawn before the handshake.
- On grant_ready in GRANT:
  - outstanding[grant_idx] increments.
  - Return to IDLE. This gives a mandatory bubble cycle: at most one grant per 2 cycles.
- Weighting, applied on each handshake:
  - If burst counter < weight[grant_idx], the burst counter increments and the rr pointer stays at grant_idx.
  - Otherwise the burst counter clears and the rr pointer moves to grant_idx+1, wrapping from REQ_NUM-1 to 0.
  - In IDLE, if the selected index differs from the rr pointer, the burst counter clears before counting.
- done_valid: outstanding[done_idx] decrements.
  - If that counter is already 0: no change, and err_underflow sets.
  - If done_idx >= REQ_NUM: ignored, and err_underflow sets.
- Simultaneous handshake and done on the same index: counter unchanged. On different indices, both updates apply in the same cycle.
- Limit handling:
  - at_limit is combinational from the counters.
  - A requester at the limit is skipped in IDLE, and the rr pointer is unaffected.
  - A grant already in GRANT completes even if a done arrives meanwhile.
  - A counter never exceeds MAX_OUTSTANDING, because grants are only issued below the limit.
- A weight change while in GRANT takes effect at the next handshake evaluation.
- Reset asserted mid-GRANT: grant_valid drops asynchronously and all counters clear. The downstream block is reset by the same rstn.

Test Plan:
- Single requester: req_valid=0001, weight=0 -> grant_idx=0, grant_valid rises 1 cycle after req_valid; with grant_ready held high, a handshake occurs every 2 cycles and outstanding[0] counts 1,2,…,8; at_limit[0]=1 and no further grant.
- Round robin with all weights 0: req_valid=1111, grant_ready=1 -> grant order 0,1,2,3,0; each outstanding=1 after 4 handshakes, the fifth grant goes to 0.
- Weighted: weight[0]=2, weight[1]=0, req_valid=0011 -> grant order 0,0,0,1,0,0,0,1.
- Limit and release: MAX_OUTSTANDING=2, requester 1 at limit, req_valid=0011 -> only 0 granted; pulse done_valid with done_idx=1 -> outstanding[1]=1 and requester 1 is granted next time the pointer reaches it.
- Simultaneous events: handshake on idx 2 and done_valid/done_idx=2 in the same cycle, starting from outstanding[2]=3 -> outstanding[2] stays 3. done_valid on idx 3 with outstanding[3]=0 -> err_underflow=1 and counter stays 0.
- Backpressure and reset: grant_ready=0 for 10 cycles -> grant_idx and grant_onehot stable with grant_valid=1; assert rstn low mid-grant -> all outputs return to reset values immediately.
